// File: rtl/sd_fifo_pkg.sv
// Shared types and constants for the prefetch-FIFO sector reader.
package sd_fifo_pkg;

    // Sector reader control states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_XFER      = 2'd2,
        ST_WAIT_DONE = 2'd3
    } sd_state_t;

    localparam int SECTOR_BYTES   = 512;
    localparam int DEF_DATA_W     = 32;
    localparam int BYTES_PER_WORD = DEF_DATA_W / 8;

    // Number of bytes carried by one FIFO word of the given width.
    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

    // Width of a byte index into one word; kept at least 1 bit wide.
    function automatic int idx_width(input int data_w);
        return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
    endfunction

endpackage

// File: rtl/sd_word_byte_ser.sv
// Word-to-byte serializer: holds one FIFO word and emits it MSB byte first.
// Handshakes: a beat transfers on either side only when its valid and ready
// are both high in the same cycle; ready may rise without valid.
module sd_word_byte_ser
    import sd_fifo_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              words_left,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_vld,
    output logic              in_rdy,
    output logic [7:0]        out_data,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              load,
    output logic              last_accept
);

    localparam int BPW   = bytes_per_word(DATA_W);
    localparam int IDX_W = idx_width(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    logic [DATA_W-1:0] word_buf;
    logic [IDX_W-1:0]  byte_idx;
    logic              buf_vld;
    logic              at_last;
    logic              accept;

    // Ready/valid glue: a new word is taken when the buffer is empty or its
    // last byte leaves this cycle, which keeps the byte stream bubble free.
    always_comb begin
        at_last     = (byte_idx == LAST_IDX);
        accept      = buf_vld & out_rdy;
        in_rdy      = en & words_left & (~buf_vld | (out_rdy & at_last));
        load        = in_rdy & in_vld;
        last_accept = accept & at_last;
        out_vld     = buf_vld;
    end

    // Byte select, most significant byte at index 0.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < BPW; i++) begin
            if (int'(byte_idx) == i) begin
                out_data = word_buf[DATA_W-1-8*i -: 8];
            end
        end
    end

    // Word buffer, byte index and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_buf <= '0;
            byte_idx <= '0;
            buf_vld  <= 1'b0;
        end else if (load) begin
            word_buf <= in_data;
            byte_idx <= '0;
            buf_vld  <= 1'b1;
        end else if (accept) begin
            if (at_last) begin
                buf_vld <= 1'b0;
            end else begin
                byte_idx <= byte_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/sd_fifo_sector_reader.sv
// Drains the prefetch FIFO in sector-sized groups, issuing one SD write
// command per sector and streaming the sector's bytes to the write engine.
// Handshakes: fifo words move on fifo_rd_vld & fifo_rd_en, bytes move on
// out_vld & out_rdy; both readies may assert without the matching valid.
module sd_fifo_sector_reader
    import sd_fifo_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int SECTOR_WORDS = 128,
    parameter int ADDR_W       = 32,
    parameter int CNT_W        = 16
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [CNT_W-1:0]  cfg_sec_num,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_rd_vld,
    output logic              fifo_rd_en,
    output logic              sd_wr_req,
    output logic [ADDR_W-1:0] sd_wr_addr,
    input  logic              sd_wr_ack,
    input  logic              sd_wr_done,
    output logic [7:0]        out_data,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    localparam int WC_W = $clog2(SECTOR_WORDS + 1);

    sd_state_t         state;
    sd_state_t         state_nxt;
    logic [CNT_W-1:0]  sec_left;
    logic [WC_W-1:0]   word_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              done_q;
    logic              ser_en;
    logic              words_left;
    logic              ser_load;
    logic              ser_last_acc;

    sd_word_byte_ser #(
        .DATA_W (DATA_W)
    ) u_ser (
        .clk         (rd_clk),
        .rst         (rd_rst),
        .en          (ser_en),
        .words_left  (words_left),
        .in_data     (fifo_rd_data),
        .in_vld      (fifo_rd_vld),
        .in_rdy      (fifo_rd_en),
        .out_data    (out_data),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .load        (ser_load),
        .last_accept (ser_last_acc)
    );

    // State register.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt  = state;
        ser_en     = 1'b0;
        sd_wr_req  = 1'b0;
        busy       = (state != ST_IDLE);
        words_left = (word_cnt != '0);
        case (state)
            ST_IDLE: begin
                if (cfg_start && (cfg_sec_num != '0)) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                sd_wr_req = 1'b1;
                if (sd_wr_ack) begin
                    state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                ser_en = 1'b1;
                if (!words_left && ser_last_acc) begin
                    state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (sd_wr_done) begin
                    state_nxt = (sec_left == CNT_W'(1)) ? ST_IDLE : ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Job bookkeeping: address, sectors left, words left in sector, done pulse.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            addr_q   <= '0;
            sec_left <= '0;
            word_cnt <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        if (cfg_sec_num != '0) begin
                            addr_q   <= cfg_base_addr;
                            sec_left <= cfg_sec_num;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (sd_wr_ack) begin
                        word_cnt <= WC_W'(SECTOR_WORDS);
                    end
                end
                ST_XFER: begin
                    if (ser_load) begin
                        word_cnt <= word_cnt - WC_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (sd_wr_done) begin
                        sec_left <= sec_left - CNT_W'(1);
                        if (sec_left == CNT_W'(1)) begin
                            done_q <= 1'b1;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // Registered outputs brought to the ports.
    always_comb begin
        sd_wr_addr = addr_q;
        done       = done_q;
        dbg_state  = state;
    end

endmodule

// File: doc/sd_fifo_sector_reader.md
Name: sd_fifo_sector_reader

Overview:
- Read-side consumer of the ethernet-to-SD prefetch FIFO.
- Drains 32-bit words through the FIFO's valid/ready read interface (fifo_rd_vld / fifo_rd_en) and groups them into 512-byte sectors.
- Issues one write command per sector to the SD write engine, then serializes each word MSB-byte-first onto a byte stream with valid/ready handshake.
- Sits in the rd_clk domain between the prefetch FIFO and the SD write controller.

Parameters:
- DATA_W, 32, FIFO word width; must be a multiple of 8.
- SECTOR_WORDS, 128, FIFO words per sector (512 bytes / 4).
- ADDR_W, 32, SD sector address width.
- CNT_W, 16, width of the sector-count request.

Ports:
- rd_clk  in  1  clock.
- rd_rst  in  1  asynchronous active-high reset.
- cfg_start  in  1  one-cycle pulse that starts a job.
- cfg_base_addr  in  ADDR_W  first sector address; sampled on cfg_start.
- cfg_sec_num  in  CNT_W  number of sectors; sampled on cfg_start.
- fifo_rd_data  in  DATA_W  prefetch FIFO head word.
- fifo_rd_vld  in  1  FIFO head valid.
- fifo_rd_en  out  1  FIFO pop/ready; a word transfers when fifo_rd_vld & fifo_rd_en.
- sd_wr_req  out  1  sector write command request.
- sd_wr_addr  out  ADDR_W  sector address of the request.
- sd_wr_ack  in  1  one-cycle pulse: command accepted, engine ready for data.
- sd_wr_done  in  1  one-cycle pulse: sector programmed.
- out_data  out  8  byte stream data.
- out_vld  out  1  byte valid.
- out_rdy  in  1  byte ready.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset values: fifo_rd_en, sd_wr_req, out_vld, busy and done are 0; sd_wr_addr and out_data are 0; FSM is IDLE; all counters are 0; the byte buffer is empty.
- Reset is asynchronous: asserting rd_rst mid-job aborts immediately. Partial sector data is lost and any unconsumed FIFO words remain in the FIFO.
- FSM states:
  - IDLE
    - cfg_start & cfg_sec_num!=0: latch the address and count, go to REQ, set busy=1.
    - cfg_start & cfg_sec_num==0: done=1 on the next cycle, stay in IDLE.
  - REQ
    - sd_wr_req=1 and sd_wr_addr is held stable.
    - On sd_wr_ack: drop sd_wr_req in the following cycle, load word_cnt=SECTOR_WORDS, go to XFER.
  - XFER
    - Fetch and serialize words; see the byte path rules below.
    - When word_cnt==0 and the last byte is accepted (out_vld & out_rdy), go to WAIT_DONE.
  - WAIT_DONE
    - On sd_wr_done: decrement sec_left.
    - If sec_left is now 0: go to IDLE, done=1 for one cycle, busy=0.
    - Otherwise: increment sd_wr_addr by 1 (wraps modulo 2^ADDR_W) and go to REQ.
- Byte path:
  - Holds word_buf, byte_idx[1:0] and buf_vld.
  - out_vld=buf_vld; out_data=word_buf[DATA_W-1-8*byte_idx -: 8].
  - fifo_rd_en = (state==XFER) & word_cnt!=0 & (~buf_vld | (out_rdy & byte_idx==3)).
  - On a FIFO transfer: word_buf<=fifo_rd_data, byte_idx<=0, buf_vld<=1, word_cnt decrements.
  - Reload happens in the same cycle the last byte is accepted, so there are no bubbles: sustained rate is 1 byte/cycle while out_rdy=1.
  - fifo_rd_en is a ready signal and may assert while fifo_rd_vld=0.
  - The byte buffer empties (buf_vld<=0) on the last byte when no reload occurs.
- Stalls:
  - An empty FIFO (fifo_rd_vld=0) stalls XFER indefinitely with out_vld=0 between words; there is no timeout.
  - out_rdy=0 holds out_data and byte_idx stable.
- Ignored events:
  - cfg_start while busy=1 is ignored.
  - sd_wr_ack outside REQ and sd_wr_done outside WAIT_DONE are ignored.
- The FIFO is never popped outside XFER, and never beyond SECTOR_WORDS words per sector.

Decomposition:
- Shared package sd_fifo_pkg holds:
  - the FSM state enum (IDLE, REQ, XFER, WAIT_DONE);
  - SECTOR_BYTES=512;
  - BYTES_PER_WORD=DATA_W/8.
- One sub-module, sd_word_byte_ser, implements the word buffer, byte index and ready/valid conversion. It has an enable input and a words-remaining gate.

Test Plan:
1. cfg_start with base 0x100, sec_num 1, FIFO preloaded with 128 words, out_rdy=1 → exactly one request at 0x100. After ack, 512 bytes in order, word 0x11223344 emitted as 11,22,33,44, no gaps. After sd_wr_done, done pulses once.
2. sec_num 3, base 0xFFFFFFFF → requests at 0xFFFFFFFF, 0x0, 0x1. Each request waits for the previous sd_wr_done. 3×128 pops total.
3. Random out_rdy (50%) and random fifo_rd_vld gaps → byte sequence matches the FIFO contents. out_data is stable while out_vld&~out_rdy. fifo_rd_en is never high outside XFER.
4. sec_num 0 → done pulse one cycle after start, no sd_wr_req. cfg_start while busy → no effect on address or count.
5. rd_rst asserted mid-XFER after 40 words → all outputs return to reset values immediately. A fresh job afterwards works normally.
6. FIFO holds 200 words, sec_num 1 → exactly 128 pops, 72 words remain, fifo_rd_en=0 after the 128th pop.
